barrett_reducer: RTL and testbench

Sequential Barrett modular reduction stage that sits directly downstream of the 64×64 parallel multiplier in the HE datapath. It consumes the full 128-bit product together with the ciphertext modulus `q` and its precomputed Barrett constant `mu`, and returns `x mod q`. A ready/valid handshake is used on both sides. One shared internal multiplier is time-multiplexed across a fixed 4-step schedule.

---
 rtl/barrett_pkg.sv | 32 +++
 rtl/barrett_mul.sv | 15 +
 rtl/barrett_reducer.sv | 170 +++++++++++++++++
 tb/tb_barrett_reducer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett reduction stage: FSM state encoding,
// width helpers for the K+1 / 2K+2 datapath, and parameter legality check.
package barrett_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MU,
        MQ,
        SUB,
        CORR,
        DONE
    } barrett_state_e;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_MOD_BITS = 60;

    // Operand width of the shared multiplier (K+1).
    function automatic int ext_w(input int k);
        return k + 1;
    endfunction

    // Full product width of the shared multiplier (2K+2).
    function automatic int prod_w(input int k);
        return 2 * k + 2;
    endfunction

    // The modulus must fit below the upstream operand width.
    function automatic bit params_legal(input int width, input int k);
        return (k >= 2) && (k <= width - 1);
    endfunction

endpackage

// File: rtl/barrett_mul.sv
// Purely combinational (K+1)x(K+1) unsigned multiplier, shared by the MU and
// MQ steps of the Barrett schedule.
module barrett_mul
    import barrett_pkg::*;
#(
    parameter int MOD_BITS = DEF_MOD_BITS
) (
    input  logic [ext_w(MOD_BITS)-1:0]  a,
    input  logic [ext_w(MOD_BITS)-1:0]  b,
    output logic [prod_w(MOD_BITS)-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/barrett_reducer.sv
// Sequential Barrett reduction: x mod q for x < q*q, using one shared
// (K+1)x(K+1) multiplier over a fixed MU -> MQ -> SUB -> CORR schedule.
// Optional feature macro: BARRETT_RANGE_CHECK_EN adds the err output, flagging
// inputs with bits at or above 2K, or results needing more than two corrections.
module barrett_reducer
    import barrett_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MOD_BITS = DEF_MOD_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*WIDTH-1:0]    x,
    input  logic [MOD_BITS-1:0]   q,
    input  logic [MOD_BITS:0]     mu,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MOD_BITS-1:0]   r
`ifdef BARRETT_RANGE_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int K   = MOD_BITS;
    localparam int KP1 = ext_w(MOD_BITS);
    localparam int PW  = prod_w(MOD_BITS);

    if (!params_legal(WIDTH, MOD_BITS)) begin : g_bad_params
        $error("barrett_reducer: MOD_BITS must be <= WIDTH-1");
    end

    barrett_state_e   state;
    logic [2*K-1:0]   x_r;      // only bits [2K-1:0] of x ever reach the math
    logic [K-1:0]     q_r;
    logic [KP1-1:0]   mu_r;
    logic [KP1-1:0]   q3_r;
    logic [KP1-1:0]   mq_r;
    logic [KP1-1:0]   t_r;

    logic             accept;
    logic [KP1-1:0]   mul_a;
    logic [KP1-1:0]   mul_b;
    logic [PW-1:0]    prod;

    logic [K+1:0]     d1;       // t - q  with a sign bit
    logic [K+1:0]     d2;       // t - 2q with a sign bit
    logic [K-1:0]     corr_r;
    logic             over2;

`ifdef BARRETT_RANGE_CHECK_EN
    logic             range_r;
`else
    logic             unused_range_bits;
    assign unused_range_bits = ^{x[2*WIDTH-1:2*K], over2};
`endif
    logic             unused_d1_msb;
    assign unused_d1_msb = d1[K];

    // Upstream may hand over a new request from DONE in the same cycle the
    // current result is consumed, giving one result every five cycles.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Steer the shared multiplier: x>>(K-1) times mu in MU, q3 times q otherwise.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        mul_a = q3_r;
        mul_b = {1'b0, q_r};
        if (state == MU) begin
            mul_a = x_r[2*K-1:K-1];
            mul_b = mu_r;
        end
    end

    barrett_mul #(
        .MOD_BITS (MOD_BITS)
    ) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    // Final correction: pick the smallest non-negative of t, t-q, t-2q.
    // Beyond two corrections the t-2q candidate is kept and over2 flags it.
    always_comb begin
        d1     = {1'b0, t_r} - {2'b00, q_r};
        d2     = {1'b0, t_r} - {1'b0, q_r, 1'b0};
        over2  = !d2[K+1] && (d2[K:0] >= {1'b0, q_r});
        corr_r = d2[K-1:0];
        if (d1[K+1]) begin
            corr_r = t_r[K-1:0];
        end else if (d2[K+1]) begin
            corr_r = d1[K-1:0];
        end
    end

    // Schedule FSM with registered datapath and outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: all datapath registers are reset too, so an aborted request leaves
    // no stale operands behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_r       <= '0;
            q_r       <= '0;
            mu_r      <= '0;
            q3_r      <= '0;
            mq_r      <= '0;
            t_r       <= '0;
            r         <= '0;
            out_valid <= 1'b0;
`ifdef BARRETT_RANGE_CHECK_EN
            range_r   <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                x_r     <= x[2*K-1:0];
                q_r     <= q;
                mu_r    <= mu;
`ifdef BARRETT_RANGE_CHECK_EN
                range_r <= |x[2*WIDTH-1:2*K];
`endif
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= MU;
                    end
                end
                MU: begin
                    q3_r  <= prod[PW-1:KP1];
                    state <= MQ;
                end
                MQ: begin
                    mq_r  <= prod[KP1-1:0];
                    state <= SUB;
                end
                SUB: begin
                    t_r   <= x_r[K:0] - mq_r;
                    state <= CORR;
                end
                CORR: begin
                    r         <= corr_r;
                    out_valid <= 1'b1;
`ifdef BARRETT_RANGE_CHECK_EN
                    err       <= range_r || over2;
`endif
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= accept ? MU : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_reducer.sv
// Scoreboard bench for barrett_reducer: stimulus pushes x % q into a queue,
// an independent monitor pops and compares on each output handshake and
// checks accept-to-valid latency and back-to-back pulse spacing.
module tb_barrett_reducer;

    localparam int W = 64;
    localparam int K = 60;

    localparam logic [K-1:0] Q = 60'hFFFFFFFFFFFFFC1;

    typedef struct {
        logic [K-1:0] r;
        logic         err;
        logic         chk_r;
        int           acc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   x_in;
    logic [K-1:0]     q_in;
    logic [K:0]       mu_in;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     r;
`ifdef BARRETT_RANGE_CHECK_EN
    logic             err;
`endif

    exp_t             exp_q[$];
    int               n_checks;
    int               n_fail;
    int               cycle;
    logic             gap_on;
    logic [127:0]     qq;

    barrett_reducer #(
        .WIDTH    (W),
        .MOD_BITS (K)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x_in),
        .q         (q_in),
        .mu        (mu_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r)
`ifdef BARRETT_RANGE_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: plain modular arithmetic on the request.
    function automatic exp_t model(input logic [127:0] v, input logic chk_r);
        logic [127:0] rem;
        exp_t e;
        rem     = v % {68'd0, Q};
        e.r     = rem[K-1:0];
        e.err   = |v[127:2*K];
        e.chk_r = chk_r;
        e.acc   = 0;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accept edge with
    // in_valid still high so the caller may chain another request.
    task automatic send(input logic [127:0] v, input logic chk_r);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        x_in     = v;
        n        = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e     = model(v, chk_r);
            e.acc = cycle;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
    endtask

    task automatic send_one(input logic [127:0] v);
        send(v, 1'b1);
        in_valid = 1'b0;
        drain();
    endtask

    // Monitor: latency/gap on each out_valid rise, data on each handshake.
    initial begin
        logic ov_prev;
        int   last_rise;
        exp_t e;
        ov_prev   = 1'b0;
        last_rise = -1;
        forever begin
            @(negedge clk);
            if (!gap_on) last_rise = -1;
            if (!rst_n) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid && !ov_prev) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_out_valid");
                    end else begin
                        check("latency", 128'(cycle - exp_q[0].acc), 128'd4);
                    end
                    if (gap_on) begin
                        if (last_rise >= 0) check("pulse_gap", 128'(cycle - last_rise), 128'd5);
                        last_rise = cycle;
                    end
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.chk_r) check("r", 128'(r), 128'(e.r));
`ifdef BARRETT_RANGE_CHECK_EN
                    check("err", 128'(err), 128'(e.err));
`endif
                end
                ov_prev = out_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] one120;
        logic [127:0] v;
        logic [127:0] v2;
        exp_t         e;

        n_checks  = 0;
        n_fail    = 0;
        cycle     = 0;
        gap_on    = 1'b0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        q_in      = Q;
        one120    = 128'd1 << 120;
        v         = one120 / {68'd0, Q};
        mu_in     = v[K:0];
        qq        = {68'd0, Q} * {68'd0, Q};

        // Reset state
        #2 rst_n = 1'b0;
        #20;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_r", 128'(r), 128'd0);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Boundary values and maximum input
        send_one(128'd0);
        send_one({68'd0, Q} - 128'd1);
        send_one({68'd0, Q});
        send_one(({68'd0, Q} - 128'd1) * ({68'd0, Q} - 128'd1));
        send_one(128'd12345);

        // Backpressure: hold DONE for 10 cycles with the next request pending
        out_ready = 1'b0;
        v  = {$urandom, $urandom, $urandom, $urandom} % qq;
        v2 = {$urandom, $urandom, $urandom, $urandom} % qq;
        send(v, 1'b1);
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        e = model(v, 1'b1);
        in_valid = 1'b1;
        x_in     = v2;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_r_stable", 128'(r), 128'(e.r));
            check("bp_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        e     = model(v2, 1'b1);
        e.acc = cycle + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Random back-to-back with in_valid held high
        gap_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom} % qq;
            send(v, 1'b1);
        end
        in_valid = 1'b0;
        drain();
        @(posedge clk);
        #1;
        gap_on = 1'b0;

        // Reset during MQ aborts the in-flight request
        v = {$urandom, $urandom, $urandom, $urandom} % qq;
        send(v, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_out_valid", 128'(out_valid), 128'd0);
        check("midreset_r", 128'(r), 128'd0);
        check("midreset_in_ready", 128'(in_ready), 128'd1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", 128'(in_ready), 128'd1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        send_one({$urandom, $urandom, $urandom, $urandom} % qq);

`ifdef BARRETT_RANGE_CHECK_EN
        // Range check: out-of-range input flags err, in-range does not
        send(128'd1 << 127, 1'b0);
        in_valid = 1'b0;
        drain();
        send_one(128'd5);
`endif

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
